// File: rtl/switch_debouncer_pkg.sv
// ---------------------------------------------------------------------------
// switch_pkg
//   Board-level constants shared by the switch conditioning path.
//   SW_WIDTH         number of slide switches on the board
//   CLK_HZ           board clock frequency
//   DEBOUNCE_MS      time a switch must hold a new level before it is believed
//   DEBOUNCE_CYCLES  the same settling time expressed in clock cycles
// ---------------------------------------------------------------------------
package switch_pkg;

   localparam int SW_WIDTH        = 16;
   localparam int CLK_HZ          = 100_000_000;
   localparam int DEBOUNCE_MS     = 10;
   localparam int DEBOUNCE_CYCLES = (CLK_HZ / 1000) * DEBOUNCE_MS;

endpackage

// File: rtl/switch_debouncer_if.sv
// ---------------------------------------------------------------------------
// switch_debouncer_if
//   Bundles the raw switch pins and the conditioned outputs.
//   sw_raw      raw switch levels (asynchronous, may bounce)
//   sw_clean    debounced levels
//   sw_rise     one-cycle pulse per bit on an accepted 0->1 change
//   sw_fall     one-cycle pulse per bit on an accepted 1->0 change
//   sw_changed  one-cycle pulse when any bit was accepted this cycle
//   Modports: master drives the pins and observes the results,
//             slave is the debouncer itself.
// ---------------------------------------------------------------------------
interface switch_debouncer_if
   import switch_pkg::*;
#(
   parameter int WIDTH = SW_WIDTH
);

   logic [WIDTH-1:0] sw_raw;
   logic [WIDTH-1:0] sw_clean;
   logic [WIDTH-1:0] sw_rise;
   logic [WIDTH-1:0] sw_fall;
   logic             sw_changed;

   modport master (
      output sw_raw,
      input  sw_clean,
      input  sw_rise,
      input  sw_fall,
      input  sw_changed
   );

   modport slave (
      input  sw_raw,
      output sw_clean,
      output sw_rise,
      output sw_fall,
      output sw_changed
   );

endinterface

// File: rtl/switch_debouncer_bit.sv
// ---------------------------------------------------------------------------
// debounce_bit
//   Conditions one switch bit: two-flop synchroniser, stability counter and
//   registered edge pulses.
//   clk    system clock
//   rst_n  asynchronous reset, active-low
//   raw    raw switch level, asynchronous to clk
//   clean  debounced level (flop output)
//   rise   one-cycle pulse, aligned with clean going 0->1
//   fall   one-cycle pulse, aligned with clean going 1->0
// ---------------------------------------------------------------------------
module debounce_bit #(
   parameter int N     = 4,
   parameter int CNT_W = $clog2(N)
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic clean,
   output logic rise,
   output logic fall
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic             s1;
   logic             s2;
   logic [CNT_W-1:0] cnt;

   // Plain two-flop synchroniser; nothing may sit between s1 and s2.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
      end else begin
         s1 <= raw;
         s2 <= s1;
      end
   end

   // The counter only runs while the synchronised level disagrees with clean;
   // any agreement (bounce back or no change) throws the count away. On the
   // N-th consecutive disagreeing edge the new level is taken and the
   // matching edge pulse is raised in the same edge, so it lines up with
   // the new clean value. Clearing cnt on acceptance means it never wraps.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt   <= '0;
         clean <= 1'b0;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         rise <= 1'b0;
         fall <= 1'b0;
         if (s2 == clean) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            cnt   <= '0;
            clean <= s2;
            rise  <= s2;
            fall  <= ~s2;
         end else begin
            cnt <= cnt + CNT_ONE;
         end
      end
   end

endmodule

// File: rtl/switch_debouncer.sv
// ---------------------------------------------------------------------------
// switch_debouncer
//   Synchronises and debounces the slide switches before they reach the
//   switch-to-LED parity chain, and reports accepted changes as pulses.
//   clk    system clock (100 MHz board clock)
//   rst_n  asynchronous reset, active-low
//   bus    switch_debouncer_if.slave: sw_raw in; sw_clean, sw_rise,
//          sw_fall, sw_changed out
//   Parameters: WIDTH bits, DEBOUNCE_CYCLES stable cycles to accept a level
//   (>= 2), CNT_W derived counter width.
// ---------------------------------------------------------------------------
module switch_debouncer
   import switch_pkg::*;
#(
   parameter int WIDTH           = SW_WIDTH,
   parameter int DEBOUNCE_CYCLES = switch_pkg::DEBOUNCE_CYCLES,
   parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
   input  logic                clk,
   input  logic                rst_n,
   switch_debouncer_if.slave   bus
);

   // Each bit is fully independent: no shared state, no priority.
   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      debounce_bit #(
         .N     (DEBOUNCE_CYCLES),
         .CNT_W (CNT_W)
      ) u_bit (
         .clk   (clk),
         .rst_n (rst_n),
         .raw   (bus.sw_raw[i]),
         .clean (bus.sw_clean[i]),
         .rise  (bus.sw_rise[i]),
         .fall  (bus.sw_fall[i])
      );
   end

   // Built only from the registered per-bit pulses, so the summary strobe
   // is valid in exactly the same cycle as the individual edges.
   assign bus.sw_changed = |(bus.sw_rise | bus.sw_fall);

endmodule

// File: tb/tb_switch_debouncer.sv
// ---------------------------------------------------------------------------
// tb_switch_debouncer
//   Directed bench for switch_debouncer with DEBOUNCE_CYCLES = 4, so an
//   accepted change appears 6 edges after the raw level settles.
// ---------------------------------------------------------------------------
module tb_switch_debouncer;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   switch_debouncer_if #(.WIDTH(16)) bus ();

   switch_debouncer #(
      .WIDTH           (16),
      .DEBOUNCE_CYCLES (4)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance to just after the next rising edge; inputs are changed and
   // outputs are sampled at this point.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [15:0] exp_clean, exp_rise;
      logic        exp_chg;
      bus.sw_raw = 16'hFFFF;
      rst_n      = 1'b0;
      repeat (3) tick();
      total++;
      if (bus.sw_clean !== 16'h0000) begin
         bad++; $display("[TB] FAIL reset_clean got=%h want=0000", bus.sw_clean);
      end
      total++;
      if (bus.sw_rise !== 16'h0000 || bus.sw_fall !== 16'h0000) begin
         bad++; $display("[TB] FAIL reset_pulses rise=%h fall=%h want=0000", bus.sw_rise, bus.sw_fall);
      end
      total++;
      if (bus.sw_changed !== 1'b0) begin
         bad++; $display("[TB] FAIL reset_changed got=%b want=0", bus.sw_changed);
      end
      rst_n = 1'b1;
      for (int i = 1; i <= 7; i++) begin
         tick();
         exp_clean = (i >= 6) ? 16'hFFFF : 16'h0000;
         exp_rise  = (i == 6) ? 16'hFFFF : 16'h0000;
         exp_chg   = (i == 6);
         total++;
         if (bus.sw_clean !== exp_clean) begin
            bad++; $display("[TB] FAIL release_clean c%0d got=%h want=%h", i, bus.sw_clean, exp_clean);
         end
         total++;
         if (bus.sw_rise !== exp_rise || bus.sw_fall !== 16'h0000) begin
            bad++; $display("[TB] FAIL release_pulse c%0d rise=%h fall=%h want rise=%h fall=0000", i, bus.sw_rise, bus.sw_fall, exp_rise);
         end
         total++;
         if (bus.sw_changed !== exp_chg) begin
            bad++; $display("[TB] FAIL release_changed c%0d got=%b want=%b", i, bus.sw_changed, exp_chg);
         end
      end
   endtask

   task automatic test_single_rise();
      logic [15:0] exp_clean, exp_rise;
      logic        exp_chg;
      bus.sw_raw = 16'h0000;
      rst_n      = 1'b0;
      tick();
      rst_n = 1'b1;
      repeat (2) tick();
      bus.sw_raw = 16'h0008;
      for (int i = 1; i <= 7; i++) begin
         tick();
         exp_clean = (i >= 6) ? 16'h0008 : 16'h0000;
         exp_rise  = (i == 6) ? 16'h0008 : 16'h0000;
         exp_chg   = (i == 6);
         total++;
         if (bus.sw_clean !== exp_clean) begin
            bad++; $display("[TB] FAIL bit3_clean c%0d got=%h want=%h", i, bus.sw_clean, exp_clean);
         end
         total++;
         if (bus.sw_rise !== exp_rise || bus.sw_fall !== 16'h0000) begin
            bad++; $display("[TB] FAIL bit3_pulse c%0d rise=%h fall=%h want rise=%h fall=0000", i, bus.sw_rise, bus.sw_fall, exp_rise);
         end
         total++;
         if (bus.sw_changed !== exp_chg) begin
            bad++; $display("[TB] FAIL bit3_changed c%0d got=%b want=%b", i, bus.sw_changed, exp_chg);
         end
      end
   endtask

   task automatic test_bounce();
      logic [15:0] bounce [4];
      logic [15:0] exp_clean, exp_rise;
      int          rises;
      bounce[0] = 16'h0009;
      bounce[1] = 16'h0008;
      bounce[2] = 16'h0009;
      bounce[3] = 16'h0008;
      rises     = 0;
      for (int j = 0; j < 4; j++) begin
         bus.sw_raw = bounce[j];
         tick();
         if (bus.sw_rise[0] === 1'b1) rises++;
      end
      bus.sw_raw = 16'h0009;
      for (int i = 1; i <= 9; i++) begin
         tick();
         if (bus.sw_rise[0] === 1'b1) rises++;
         exp_clean = (i >= 6) ? 16'h0009 : 16'h0008;
         exp_rise  = (i == 6) ? 16'h0001 : 16'h0000;
         total++;
         if (bus.sw_clean !== exp_clean) begin
            bad++; $display("[TB] FAIL bounce_clean c%0d got=%h want=%h", i, bus.sw_clean, exp_clean);
         end
         total++;
         if (bus.sw_rise !== exp_rise || bus.sw_fall !== 16'h0000) begin
            bad++; $display("[TB] FAIL bounce_pulse c%0d rise=%h fall=%h want rise=%h fall=0000", i, bus.sw_rise, bus.sw_fall, exp_rise);
         end
      end
      total++;
      if (rises != 1) begin
         bad++; $display("[TB] FAIL bounce_rise_count got=%0d want=1", rises);
      end
   endtask

   task automatic test_glitch();
      bus.sw_raw = 16'h8009;
      repeat (3) tick();
      bus.sw_raw = 16'h0009;
      for (int i = 1; i <= 10; i++) begin
         tick();
         total++;
         if (bus.sw_clean !== 16'h0009) begin
            bad++; $display("[TB] FAIL glitch_clean c%0d got=%h want=0009", i, bus.sw_clean);
         end
         total++;
         if (bus.sw_rise !== 16'h0000 || bus.sw_fall !== 16'h0000 || bus.sw_changed !== 1'b0) begin
            bad++; $display("[TB] FAIL glitch_pulse c%0d rise=%h fall=%h chg=%b want all 0", i, bus.sw_rise, bus.sw_fall, bus.sw_changed);
         end
      end
   endtask

   task automatic test_multi_bit();
      logic [15:0] exp_clean, exp_rise, exp_fall;
      logic        exp_chg;
      bus.sw_raw = 16'h00FF;
      rst_n      = 1'b0;
      tick();
      rst_n = 1'b1;
      repeat (8) tick();
      total++;
      if (bus.sw_clean !== 16'h00FF) begin
         bad++; $display("[TB] FAIL multi_start got=%h want=00FF", bus.sw_clean);
      end
      bus.sw_raw = 16'hFF00;
      for (int i = 1; i <= 7; i++) begin
         tick();
         exp_clean = (i >= 6) ? 16'hFF00 : 16'h00FF;
         exp_rise  = (i == 6) ? 16'hFF00 : 16'h0000;
         exp_fall  = (i == 6) ? 16'h00FF : 16'h0000;
         exp_chg   = (i == 6);
         total++;
         if (bus.sw_clean !== exp_clean) begin
            bad++; $display("[TB] FAIL multi_clean c%0d got=%h want=%h", i, bus.sw_clean, exp_clean);
         end
         total++;
         if (bus.sw_rise !== exp_rise) begin
            bad++; $display("[TB] FAIL multi_rise c%0d got=%h want=%h", i, bus.sw_rise, exp_rise);
         end
         total++;
         if (bus.sw_fall !== exp_fall) begin
            bad++; $display("[TB] FAIL multi_fall c%0d got=%h want=%h", i, bus.sw_fall, exp_fall);
         end
         total++;
         if (bus.sw_changed !== exp_chg) begin
            bad++; $display("[TB] FAIL multi_changed c%0d got=%b want=%b", i, bus.sw_changed, exp_chg);
         end
      end
   endtask

   task automatic test_reset_mid_count();
      logic [15:0] exp_clean, exp_rise;
      logic        exp_chg;
      bus.sw_raw = 16'hFF10;
      repeat (5) tick();
      total++;
      if (bus.sw_clean !== 16'hFF00) begin
         bad++; $display("[TB] FAIL midrst_pending got=%h want=FF00", bus.sw_clean);
      end
      rst_n = 1'b0;
      #1;
      total++;
      if (bus.sw_clean !== 16'h0000 || bus.sw_changed !== 1'b0) begin
         bad++; $display("[TB] FAIL midrst_async clean=%h chg=%b want 0000/0", bus.sw_clean, bus.sw_changed);
      end
      repeat (2) tick();
      total++;
      if (bus.sw_clean !== 16'h0000) begin
         bad++; $display("[TB] FAIL midrst_hold got=%h want=0000", bus.sw_clean);
      end
      rst_n = 1'b1;
      for (int i = 1; i <= 7; i++) begin
         tick();
         exp_clean = (i >= 6) ? 16'hFF10 : 16'h0000;
         exp_rise  = (i == 6) ? 16'hFF10 : 16'h0000;
         exp_chg   = (i == 6);
         total++;
         if (bus.sw_clean !== exp_clean) begin
            bad++; $display("[TB] FAIL midrst_clean c%0d got=%h want=%h", i, bus.sw_clean, exp_clean);
         end
         total++;
         if (bus.sw_rise !== exp_rise || bus.sw_changed !== exp_chg) begin
            bad++; $display("[TB] FAIL midrst_pulse c%0d rise=%h chg=%b want rise=%h chg=%b", i, bus.sw_rise, bus.sw_changed, exp_rise, exp_chg);
         end
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      bus.sw_raw = 16'h0000;
      test_reset();
      test_single_rise();
      test_bounce();
      test_glitch();
      test_multi_bit();
      test_reset_mid_count();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
